// File: rtl/wb_regfile.sv
// Writeback stage register file: picks load or execute data, merges it byte-wise
// into the GPRs, serves two bypassed decode read ports, and forwards CP0 writes.
module wb_regfile #(
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwb_mem_r,
  input  logic             memwb_reg_w,
  input  logic [3:0]       reg_byte_w_en,
  input  logic [4:0]       memwb_rd_addr,
  input  logic [31:0]      memwb_memdata,
  input  logic [31:0]      memwb_exdata,
  input  logic [4:0]       memwb_cp0_dst_addr,
  input  logic             memwb_cp0_w_en,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  input  logic [4:0]       dbg_addr,
  output logic [31:0]      rs_data,
  output logic [31:0]      rt_data,
  output logic [31:0]      dbg_data,
  output logic             cp0_w_en,
  output logic [4:0]       cp0_w_addr,
  output logic [31:0]      cp0_w_data,
  output logic [CNT_W-1:0] wb_count
);

  logic [31:0]      r_regs [NREG];
  logic [CNT_W-1:0] r_count;
  logic [31:0]      w_wb_val;
  logic             w_we;
  logic             w_byp;

  assign w_wb_val = memwb_mem_r ? memwb_memdata : memwb_exdata;
  assign w_we     = memwb_reg_w && (memwb_rd_addr != 5'd0) && (reg_byte_w_en != 4'd0);
  // Bypass is suppressed during reset so readers see storage that is being cleared.
  assign w_byp    = w_we && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_count <= '0;
    end else if (w_we) begin
      for (int b = 0; b < 4; b++)
        if (reg_byte_w_en[b]) r_regs[memwb_rd_addr][8*b +: 8] <= w_wb_val[8*b +: 8];
      r_count <= r_count + 1'b1;
    end
  end

  always_comb begin
    rs_data = r_regs[rs_addr];
    if (w_byp && (rs_addr == memwb_rd_addr))
      for (int b = 0; b < 4; b++)
        if (reg_byte_w_en[b]) rs_data[8*b +: 8] = w_wb_val[8*b +: 8];
    if (rs_addr == 5'd0) rs_data = '0;
  end

  always_comb begin
    rt_data = r_regs[rt_addr];
    if (w_byp && (rt_addr == memwb_rd_addr))
      for (int b = 0; b < 4; b++)
        if (reg_byte_w_en[b]) rt_data[8*b +: 8] = w_wb_val[8*b +: 8];
    if (rt_addr == 5'd0) rt_data = '0;
  end

  assign dbg_data   = (dbg_addr == 5'd0) ? 32'd0 : r_regs[dbg_addr];
  assign cp0_w_en   = memwb_cp0_w_en && !reset;
  assign cp0_w_addr = memwb_cp0_dst_addr;
  assign cp0_w_data = memwb_exdata;
  assign wb_count   = r_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile (CNT_W=4 build so the counter wrap is reachable).
module tb_wb_regfile;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          memwb_mem_r, memwb_reg_w, memwb_cp0_w_en;
  logic [3:0]    reg_byte_w_en;
  logic [4:0]    memwb_rd_addr, memwb_cp0_dst_addr, rs_addr, rt_addr, dbg_addr;
  logic [31:0]   memwb_memdata, memwb_exdata;
  logic [31:0]   rs_data, rt_data, dbg_data, cp0_w_data;
  logic          cp0_w_en;
  logic [4:0]    cp0_w_addr;
  logic [CW-1:0] wb_count;

  wb_regfile #(.NREG(32), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .memwb_mem_r(memwb_mem_r), .memwb_reg_w(memwb_reg_w),
    .reg_byte_w_en(reg_byte_w_en), .memwb_rd_addr(memwb_rd_addr),
    .memwb_memdata(memwb_memdata), .memwb_exdata(memwb_exdata),
    .memwb_cp0_dst_addr(memwb_cp0_dst_addr), .memwb_cp0_w_en(memwb_cp0_w_en),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .dbg_addr(dbg_addr),
    .rs_data(rs_data), .rt_data(rt_data), .dbg_data(dbg_data),
    .cp0_w_en(cp0_w_en), .cp0_w_addr(cp0_w_addr), .cp0_w_data(cp0_w_data),
    .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef enum int {S_RS, S_RT, S_DBG, S_CNT, S_CP0EN, S_CP0A, S_CP0D} sel_t;
  typedef struct { string tag; sel_t sel; logic [31:0] exp; } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic push(input string tag, input sel_t sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        S_RS:    obs = rs_data;
        S_RT:    obs = rt_data;
        S_DBG:   obs = dbg_data;
        S_CNT:   obs = 32'(wb_count);
        S_CP0EN: obs = 32'(cp0_w_en);
        S_CP0A:  obs = 32'(cp0_w_addr);
        default: obs = cp0_w_data;
      endcase
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic idle();
    memwb_mem_r = 0; memwb_reg_w = 0; reg_byte_w_en = 4'h0; memwb_rd_addr = 0;
    memwb_memdata = 0; memwb_exdata = 0; memwb_cp0_dst_addr = 0; memwb_cp0_w_en = 0;
  endtask

  // Present an execute-result write for one cycle, then return to idle at the next negedge.
  task automatic wr(input logic [4:0] rd, input logic [31:0] val, input logic [3:0] be);
    @(negedge clk);
    idle();
    memwb_reg_w = 1; memwb_rd_addr = rd; memwb_exdata = val; reg_byte_w_en = be;
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    rs_addr = 0; rt_addr = 0; dbg_addr = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;

    // Every register reads zero after reset.
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      #1 push($sformatf("rst_dbg%0d", a), S_DBG, 32'd0);
      drain();
    end
    push("rst_cnt", S_CNT, 0); push("rst_cp0en", S_CP0EN, 0); drain();

    // Full-word write with same-cycle bypass.
    @(negedge clk);
    memwb_reg_w = 1; memwb_rd_addr = 5; memwb_exdata = 32'h12345678; reg_byte_w_en = 4'hF;
    rs_addr = 5; dbg_addr = 5;
    #1 push("byp_rs", S_RS, 32'h12345678); push("pre_dbg5", S_DBG, 0); push("pre_cnt", S_CNT, 0);
    drain();
    @(negedge clk); idle();
    #1 push("post_dbg5", S_DBG, 32'h12345678); push("cnt1", S_CNT, 1); drain();

    // Load with low-half byte enables merges into the existing value.
    @(negedge clk);
    memwb_reg_w = 1; memwb_mem_r = 1; memwb_memdata = 32'hAABBCCDD; memwb_exdata = 32'h55555555;
    reg_byte_w_en = 4'b0011; memwb_rd_addr = 5; rs_addr = 5; rt_addr = 5;
    #1 push("merge_rs", S_RS, 32'h1234CCDD); push("merge_rt", S_RT, 32'h1234CCDD);
    push("merge_dbg_old", S_DBG, 32'h12345678); drain();
    @(negedge clk); idle();
    #1 push("merge_dbg", S_DBG, 32'h1234CCDD); push("cnt2", S_CNT, 2); drain();

    // Single top byte from execute data.
    @(negedge clk);
    memwb_reg_w = 1; memwb_exdata = 32'hEE000000; reg_byte_w_en = 4'b1000; memwb_rd_addr = 5;
    #1 push("top_rt", S_RT, 32'hEE34CCDD); drain();
    @(negedge clk); idle();
    #1 push("top_dbg", S_DBG, 32'hEE34CCDD); push("cnt3", S_CNT, 3); drain();

    // $0 writes are dropped and not counted.
    @(negedge clk);
    memwb_reg_w = 1; memwb_rd_addr = 0; memwb_exdata = 32'hFFFFFFFF; reg_byte_w_en = 4'hF;
    rs_addr = 0; rt_addr = 0; dbg_addr = 0;
    #1 push("r0_rs", S_RS, 0); push("r0_rt", S_RT, 0); drain();
    @(negedge clk); idle();
    #1 push("r0_dbg", S_DBG, 0); push("r0_cnt", S_CNT, 3); drain();

    // Zero byte enables: no write, no bypass, no count.
    wr(7, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    memwb_reg_w = 1; memwb_rd_addr = 7; memwb_exdata = 32'h0; reg_byte_w_en = 4'h0;
    rt_addr = 7; rs_addr = 5; dbg_addr = 7;
    #1 push("be0_rt", S_RT, 32'hCAFEF00D); push("other_rs", S_RS, 32'hEE34CCDD); drain();
    @(negedge clk); idle();
    #1 push("be0_dbg", S_DBG, 32'hCAFEF00D); push("be0_cnt", S_CNT, 4); drain();

    // CP0 pass-through with no GPR write.
    @(negedge clk);
    memwb_cp0_w_en = 1; memwb_cp0_dst_addr = 12; memwb_exdata = 32'h0000FF01; memwb_rd_addr = 12;
    dbg_addr = 12;
    #1 push("cp0_en", S_CP0EN, 1); push("cp0_addr", S_CP0A, 12); push("cp0_data", S_CP0D, 32'h0000FF01);
    drain();
    @(negedge clk); idle();
    #1 push("cp0_nogpr", S_DBG, 0); push("cp0_cnt", S_CNT, 4); push("cp0_off", S_CP0EN, 0); drain();

    // Reset while a write to r3 is presented.
    wr(3, 32'h33333333, 4'hF);
    @(negedge clk);
    reset = 1; memwb_reg_w = 1; memwb_rd_addr = 3; memwb_exdata = 32'h77777777; reg_byte_w_en = 4'hF;
    memwb_cp0_w_en = 1; rs_addr = 3;
    #1 push("rst_nobyp", S_RS, 32'h33333333); push("rst_cp0en", S_CP0EN, 0); push("pre_rst_cnt", S_CNT, 5);
    drain();
    @(negedge clk);
    #1 push("rst_rs3", S_RS, 0); drain();
    reset = 0; idle(); dbg_addr = 3;
    #1 push("rst_dbg3", S_DBG, 0); push("rst_cnt0", S_CNT, 0); drain();
    dbg_addr = 5;
    #1 push("rst_dbg5", S_DBG, 0); drain();

    // First write after reset lands normally.
    wr(9, 32'h00000099, 4'hF);
    dbg_addr = 9;
    #1 push("after_rst_dbg9", S_DBG, 32'h99); push("after_rst_cnt", S_CNT, 1); drain();

    // Drive the 4-bit counter to its max, then one more write wraps it.
    for (int i = 0; i < 14; i++) wr(5'(i + 10), 32'(i), 4'hF);
    #1 push("cnt_max", S_CNT, 15); drain();
    wr(31, 32'hDEADBEEF, 4'hF);
    dbg_addr = 31;
    #1 push("cnt_wrap", S_CNT, 0); push("wrap_dbg31", S_DBG, 32'hDEADBEEF); drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
